// File: rtl/fifo_drain_pkg.sv
// Shared types and widths for the FIFO drain block: FSM state encoding,
// stream data width and statistics counter widths.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;
    localparam int ERR_W  = 8;

endpackage

// File: rtl/fifo_drain_buf.sv
// Circular output buffer for fifo_drain: tail-side push of captured words,
// head-side pop on the valid/ready handshake, occupancy counter.
module drain_buf
    import fifo_drain_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [DATA_W-1:0]       push_data,
    input  logic                    ready,
    output logic                    m_valid,
    output logic [DATA_W-1:0]       m_data,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     head;
    logic [AW-1:0]     tail;
    logic              pop;

    assign m_valid = (count != '0);
    assign pop     = m_valid & ready;
    // Drive zero while empty so the stream never exposes unreset storage.
    assign m_data  = m_valid ? mem[head] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// FIFO drain: issues reads against a two-cycle-latency FIFO, reserves a buffer
// slot per read and streams the words out. Optional FIFO_DRAIN_STATS_EN adds counters.
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int BUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              drain_en,
    input  logic              fifo_empty,
    input  logic              fifo_rd_ack,
    input  logic              fifo_rd_err,
    input  logic [DATA_W-1:0] fifo_d_out,
    output logic              fifo_rd_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [CNT_W-1:0]  word_count,
    output logic [ERR_W-1:0]  err_count
`endif
);

    localparam int              AW      = $clog2(BUF_DEPTH);
    localparam logic [AW+1:0]   DEPTH_V = (AW+2)'(BUF_DEPTH);

    state_t          state;
    state_t          next_state;
    logic            req_d1;
    logic            ack_d1;
    logic [1:0]      inflight;
    logic [AW:0]     count;
    logic [AW+1:0]   reserved;

    assign inflight = {1'b0, req_d1} + {1'b0, ack_d1};
    // Every outstanding read already owns a slot, so it counts as occupied.
    assign reserved = {1'b0, count} + {{AW{1'b0}}, inflight};

    assign fifo_rd_en = (state == RUN) && !fifo_empty && (reserved < DEPTH_V);
    assign busy       = (inflight != 2'd0) || (count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (drain_en) next_state = RUN;
            RUN:  if (!drain_en) next_state = STOP;
            STOP: begin
                if (drain_en) begin
                    next_state = RUN;
                end else if (inflight == 2'd0) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // An error response never becomes pending data, even if ack is also raised.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_d1 <= 1'b0;
            ack_d1 <= 1'b0;
        end else begin
            req_d1 <= fifo_rd_en;
            ack_d1 <= req_d1 & fifo_rd_ack & ~fifo_rd_err;
        end
    end

    drain_buf #(
        .DEPTH     (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ack_d1),
        .push_data (fifo_d_out),
        .ready     (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .count     (count)
    );

`ifdef FIFO_DRAIN_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_count <= '0;
            err_count  <= '0;
        end else begin
            if (m_valid && m_ready && (word_count != '1)) begin
                word_count <= word_count + 1'b1;
            end
            if (req_d1 && fifo_rd_err && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Self-checking bench for fifo_drain: a queue-based FIFO model with lagging
// empty flag feeds the DUT; a queue of accepted words predicts the stream.
module tb_fifo_drain;
    import fifo_drain_pkg::*;

    localparam int BUF_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        drain_en;
    logic        fifo_empty;
    logic        fifo_rd_ack;
    logic        fifo_rd_err;
    logic [31:0] fifo_d_out;
    logic        fifo_rd_en;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        busy;
`ifdef FIFO_DRAIN_STATS_EN
    logic [15:0] word_count;
    logic [7:0]  err_count;
`endif

    fifo_drain #(
        .BUF_DEPTH   (BUF_DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .drain_en    (drain_en),
        .fifo_empty  (fifo_empty),
        .fifo_rd_ack (fifo_rd_ack),
        .fifo_rd_err (fifo_rd_err),
        .fifo_d_out  (fifo_d_out),
        .fifo_rd_en  (fifo_rd_en),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .busy        (busy)
`ifdef FIFO_DRAIN_STATS_EN
        ,
        .word_count  (word_count),
        .err_count   (err_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    bit          req_prev   = 1'b0;
    bit          ack_pend   = 1'b0;
    bit          drain_prev = 1'b0;
    bit          hist0      = 1'b1;
    bit          hist1      = 1'b1;
    logic [31:0] word_pend  = '0;
    int          lag        = 0;
    int          fault_pct  = 0;
    int          cycle      = 0;
    int          req_count, err_pulses, words_out, first_req, first_valid;
    int          stat_words = 0;
    int          stat_errs  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    task automatic clearTallies();
        req_count   = 0;
        err_pulses  = 0;
        words_out   = 0;
        first_req   = -1;
        first_valid = -1;
    endtask

    task automatic checkStats();
`ifdef FIFO_DRAIN_STATS_EN
        checkOutput("word_count", 32'(word_count), 32'(stat_words));
        checkOutput("err_count", 32'(err_count), 32'(stat_errs));
`endif
    endtask

    // One cycle: the FIFO model answers last cycle's request, inputs are
    // driven at the falling edge, then the stream is checked against exp_q.
    task automatic applyStimulus(input bit drain, input int ready_pct);
        bit cur;
        @(negedge clk);
        cycle++;
        fifo_d_out  = ack_pend ? word_pend : $urandom();
        ack_pend    = 1'b0;
        fifo_rd_ack = 1'b0;
        fifo_rd_err = 1'b0;
        if (req_prev) begin
            if (fifo_q.size() != 0 && $urandom_range(99) >= fault_pct) begin
                fifo_rd_ack = 1'b1;
                word_pend   = fifo_q.pop_front();
                ack_pend    = 1'b1;
                exp_q.push_back(word_pend);
            end else if (fifo_q.size() == 0 || $urandom_range(1) == 1) begin
                fifo_rd_err = 1'b1;
                err_pulses++;
                if (stat_errs < 255) stat_errs++;
            end
        end
        cur = (fifo_q.size() == 0);
        case (lag)
            0:       fifo_empty = cur;
            1:       fifo_empty = hist0;
            default: fifo_empty = hist1;
        endcase
        hist1    = hist0;
        hist0    = cur;
        drain_en = drain;
        m_ready  = ($urandom_range(99) < ready_pct);
        #1;
        checkOutput("busy", 32'(busy), 32'(req_prev || exp_q.size() != 0));
        if (!drain_prev) checkOutput("no_read_when_stopped", 32'(fifo_rd_en), 32'd0);
        if (dut.u_buf.push) checkOutput("capture_has_room", 32'(dut.u_buf.count < BUF_DEPTH), 32'd1);
        if (m_valid && exp_q.size() == 0) begin
            checkOutput("spurious_word", 32'(m_valid), 32'd0);
        end else if (m_valid && m_ready) begin
            checkOutput("stream_data", m_data, exp_q.pop_front());
            words_out++;
            if (stat_words < 65535) stat_words++;
        end
        if (m_valid && first_valid < 0) first_valid = cycle;
        if (fifo_rd_en) begin
            req_count++;
            if (first_req < 0) first_req = cycle;
        end
        req_prev   = fifo_rd_en;
        drain_prev = drain;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checkOutput("reset_rd_en", 32'(fifo_rd_en), 32'd0);
        checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset_m_data", m_data, 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        exp_q.delete();
        ack_pend    = 1'b0;
        req_prev    = 1'b0;
        drain_prev  = 1'b0;
        drain_en    = 1'b0;
        fifo_rd_ack = 1'b0;
        fifo_rd_err = 1'b0;
        stat_words  = 0;
        stat_errs   = 0;
        checkStats();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        drain_en    = 1'b0;
        fifo_empty  = 1'b1;
        fifo_rd_ack = 1'b0;
        fifo_rd_err = 1'b0;
        fifo_d_out  = '0;
        m_ready     = 1'b0;
        applyReset();

        // Four preloaded words stream out in order with three-cycle latency.
        lag = 0;
        fault_pct = 0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hA0 + 32'(i));
        repeat (3) applyStimulus(1'b0, 100);
        clearTallies();
        repeat (12) applyStimulus(1'b1, 100);
        checkOutput("s1_reads", 32'(req_count), 32'd4);
        checkOutput("s1_latency", 32'(first_valid - first_req), 32'd3);
        checkOutput("s1_words", 32'(words_out), 32'd4);
        repeat (4) applyStimulus(1'b0, 100);

        // Back-pressure: only BUF_DEPTH reads until the consumer releases.
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'hB0 + 32'(i));
        repeat (3) applyStimulus(1'b0, 0);
        clearTallies();
        repeat (15) applyStimulus(1'b1, 0);
        checkOutput("s2_reads_blocked", 32'(req_count), 32'd4);
        checkOutput("s2_valid_held", 32'(m_valid), 32'd1);
        repeat (20) applyStimulus(1'b1, 100);
        checkOutput("s2_words", 32'(words_out), 32'd8);
        checkOutput("s2_fifo_drained", 32'(fifo_q.size()), 32'd0);
        repeat (4) applyStimulus(1'b0, 100);

        // One word behind a two-cycle stale empty flag: two over-reads.
        applyReset();
        lag = 2;
        fifo_q.push_back(32'hC0FFEE01);
        repeat (4) applyStimulus(1'b0, 100);
        clearTallies();
        repeat (12) applyStimulus(1'b1, 100);
        checkOutput("s3_reads", 32'(req_count), 32'd3);
        checkOutput("s3_errors", 32'(err_pulses), 32'd2);
        checkOutput("s3_words", 32'(words_out), 32'd1);
        checkStats();
        repeat (4) applyStimulus(1'b0, 100);

        // Drop drain_en with reads in flight; they still land, then IDLE.
        lag = 0;
        for (int i = 0; i < 6; i++) fifo_q.push_back(32'hD0 + 32'(i));
        repeat (3) applyStimulus(1'b0, 100);
        clearTallies();
        repeat (3) applyStimulus(1'b1, 100);
        repeat (10) applyStimulus(1'b0, 100);
        checkOutput("s4_all_delivered", 32'(words_out), 32'(req_count));
        checkOutput("s4_state_idle", 32'(dut.state), 32'(IDLE));

        // Reset with a full buffer discards everything at once.
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hE0 + 32'(i));
        repeat (10) applyStimulus(1'b1, 0);
        checkOutput("s5_buffered", 32'(m_valid), 32'd1);
        applyReset();
        clearTallies();
        repeat (6) applyStimulus(1'b0, 100);
        checkOutput("s5_quiet_valid", 32'(m_valid), 32'd0);
        checkOutput("s5_quiet_words", 32'(words_out), 32'd0);

        // Random traffic: stale empty, injected errors, random ready/drain.
        fault_pct = 10;
        clearTallies();
        for (int i = 0; i < 300; i++) begin
            if (i % 5 == 0 && fifo_q.size() < 16) begin
                int n;
                n = $urandom_range(2, 0);
                for (int k = 0; k < n; k++) fifo_q.push_back($urandom());
            end
            if (i % 40 == 0) lag = $urandom_range(2, 0);
            applyStimulus($urandom_range(99) < 90, 60);
        end
        fault_pct = 0;
        for (int i = 0; i < 200 && (fifo_q.size() != 0 || exp_q.size() != 0 || busy); i++) begin
            applyStimulus(1'b1, 100);
        end
        repeat (6) applyStimulus(1'b0, 100);
        checkOutput("s6_drained", 32'(fifo_q.size() + exp_q.size()), 32'd0);
        checkOutput("s6_idle_busy", 32'(busy), 32'd0);
        checkOutput("s6_volume", 32'(words_out >= 20), 32'd1);
        checkStats();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
